// File: rtl/seq_muldiv_8bit.sv
// Iterative unsigned multiply (shift-add) / restoring divide with start/done handshake.
// Optional: define MULDIV_EARLY_EXIT_EN to let multiplies finish once the remaining multiplier is zero.
module seq_muldiv_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] mul_res,
  output logic [2*WIDTH-1:0] div_res
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic               is_div, dbz;
  logic [2*WIDTH-1:0] mcand, mcand_next, acc, acc_next;
  logic [WIDTH-1:0]   opb, opb_next, dvd, dvd_next, rem, rem_next;
  logic [WIDTH+1:0]   trial;
  logic               accept, finish;

  always_comb begin
    acc_next   = acc;
    mcand_next = mcand << 1;
    opb_next   = opb >> 1;
    if (opb[0]) acc_next = acc + mcand;

    // trial subtract on the shifted remainder; the top bit of trial is the borrow
    trial = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, opb};
    if (trial[WIDTH+1]) begin
      rem_next = {rem[WIDTH-2:0], dvd[WIDTH-1]};
      dvd_next = {dvd[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      dvd_next = {dvd[WIDTH-2:0], 1'b1};
    end

    accept = (state == IDLE) && start;
    finish = (state == RUN) && (cnt == CW'(1));
`ifdef MULDIV_EARLY_EXIT_EN
    if ((state == RUN) && !is_div && (opb_next == '0)) finish = 1'b1;
`else
`endif

    state_next = state;
    if (accept)      state_next = RUN;
    else if (finish) state_next = IDLE;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      dbz         <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      opb         <= '0;
      dvd         <= '0;
      rem         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      mul_res     <= '0;
      div_res     <= '0;
    end else begin
      state <= state_next;
      done  <= finish;
      if (accept) begin
        is_div <= op_div;
        dbz    <= op_div && (b == '0);
        mcand  <= {{WIDTH{1'b0}}, a};
        opb    <= b;
        dvd    <= a;
        rem    <= '0;
        acc    <= '0;
        // divide by zero needs no iterations, so it completes on the very next edge
        cnt    <= (op_div && (b == '0)) ? CW'(1) : CW'(WIDTH);
      end else if (state == RUN) begin
        cnt   <= cnt - CW'(1);
        acc   <= acc_next;
        mcand <= mcand_next;
        if (!is_div) opb <= opb_next;
        rem   <= rem_next;
        dvd   <= dvd_next;
        if (finish) begin
          div_by_zero <= is_div && dbz;
          if (!is_div)  mul_res <= acc_next;
          else if (dbz) div_res <= {dvd, {WIDTH{1'b1}}};
          else          div_res <= {rem_next, dvd_next};
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_muldiv_8bit.sv
// Randomized/directed bench for seq_muldiv_8bit against an arithmetic reference model.
module tb_seq_muldiv_8bit;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               op_div = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               busy, done, div_by_zero;
  logic [2*WIDTH-1:0] mul_res, div_res;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_mul = '0;
  logic [15:0] exp_div = '0;
  logic        exp_dbz = 1'b0;

  seq_muldiv_8bit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .mul_res(mul_res), .div_res(div_res)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input logic op, input logic [7:0] vb);
    int n;
    if (op) return (vb == 0) ? 1 : 8;
`ifdef MULDIV_EARLY_EXIT_EN
    n = 0;
    for (int i = 0; i < 8; i++) if (vb[i]) n = i + 1;
    return (n < 1) ? 1 : n;
`else
    n = 8;
    return n;
`endif
  endfunction

  function automatic void model(input logic op, input logic [7:0] va, input logic [7:0] vb);
    int unsigned ua, ub;
    ua = va; ub = vb;
    if (!op) begin
      exp_mul = 16'(ua * ub);
      exp_dbz = 1'b0;
    end else if (ub == 0) begin
      exp_div = {va, 8'hFF};
      exp_dbz = 1'b1;
    end else begin
      exp_div = {8'(ua % ub), 8'(ua / ub)};
      exp_dbz = 1'b0;
    end
  endfunction

  task automatic start_op(input logic op, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    op_div = op; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); op_div = 1'($urandom);
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", div_by_zero); end
    checks++; if (mul_res !== 16'h0) begin errors++; $display("FAIL reset_mul got %h exp 0000", mul_res); end
    checks++; if (div_res !== 16'h0) begin errors++; $display("FAIL reset_div got %h exp 0000", div_res); end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL idle_quiet got busy=%b done=%b exp 0 0", busy, done);
      end
    end
  endtask

  task automatic test_arith();
    logic       t_op [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] t_a  [7] = '{8'd13, 8'd255, 8'd200, 8'd5, 8'd2, 8'd255, 8'd77};
    logic [7:0] t_b  [7] = '{8'd11, 8'd255, 8'd7,   8'd0, 8'd3, 8'd1,   8'd0};
    logic op; logic [7:0] va, vb; int n, lat;
    for (int i = 0; i < 57; i++) begin
      if (i < 7) begin
        op = t_op[i]; va = t_a[i]; vb = t_b[i];
      end else begin
        op = 1'($urandom); va = 8'($urandom);
        vb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      lat = lat_of(op, vb);
      model(op, va, vb);
      start_op(op, va, vb);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL op%0d_busy got %b exp 1", i, busy); end
      n = 0;
      wait_done(n);
      checks++; if (n != lat) begin errors++; $display("FAIL op%0d_latency got %0d exp %0d", i, n, lat); end
      checks++; if (mul_res !== exp_mul) begin errors++; $display("FAIL op%0d_mul got %h exp %h", i, mul_res, exp_mul); end
      checks++; if (div_res !== exp_div) begin errors++; $display("FAIL op%0d_div got %h exp %h", i, div_res, exp_div); end
      checks++; if (div_by_zero !== exp_dbz) begin errors++; $display("FAIL op%0d_dbz got %b exp %b", i, div_by_zero, exp_dbz); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op%0d_busy_done got %b exp 0", i, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL op%0d_done_pulse got %b exp 0", i, done); end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    model(1'b0, 8'd9, 8'd9);
    start_op(1'b0, 8'd9, 8'd9);
    n = 0;
    @(negedge clk); n++;
    @(negedge clk); n++;
    a = 8'd1; b = 8'd1; op_div = 1'b0; start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    wait_done(n);
    checks++; if (n != lat_of(1'b0, 8'd9)) begin errors++; $display("FAIL ignore_latency got %0d exp %0d", n, lat_of(1'b0, 8'd9)); end
    checks++; if (mul_res !== 16'h0051) begin errors++; $display("FAIL ignore_mul got %h exp 0051", mul_res); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued got busy=%b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    model(1'b0, 8'd13, 8'd11);
    start_op(1'b0, 8'd13, 8'd11);
    n = 0;
    wait_done(n);
    checks++; if (mul_res !== 16'h008F) begin errors++; $display("FAIL b2b_first_mul got %h exp 008F", mul_res); end
    op_div = 1'b1; a = 8'd200; b = 8'd7; start = 1'b1;
    model(1'b1, 8'd200, 8'd7);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done); end
    n = 0;
    wait_done(n);
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_latency got %0d exp 8", n); end
    checks++; if (div_res !== 16'h041C) begin errors++; $display("FAIL b2b_div got %h exp 041C", div_res); end
    checks++; if (mul_res !== 16'h008F) begin errors++; $display("FAIL b2b_mul_kept got %h exp 008F", mul_res); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL b2b_dbz got %b exp 0", div_by_zero); end
  endtask

  task automatic test_reset_midop();
    int n;
    start_op(1'b1, 8'd100, 8'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (mul_res !== 16'h0 || div_res !== 16'h0) begin
      errors++; $display("FAIL midrst_results got %h %h exp 0000 0000", mul_res, div_res);
    end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dbz got %b exp 0", div_by_zero); end
    exp_mul = '0; exp_div = '0; exp_dbz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses exp 0", n); end
    model(1'b0, 8'd6, 8'd7);
    start_op(1'b0, 8'd6, 8'd7);
    n = 0;
    wait_done(n);
    checks++; if (n != lat_of(1'b0, 8'd7)) begin errors++; $display("FAIL midrst_after_lat got %0d exp %0d", n, lat_of(1'b0, 8'd7)); end
    checks++; if (mul_res !== exp_mul || div_res !== exp_div) begin
      errors++; $display("FAIL midrst_after_res got %h %h exp %h %h", mul_res, div_res, exp_mul, exp_div);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
